// File: rtl/puf_soc_pkg.sv
// Shared definitions for the PUF SoC frame serializer: state encoding,
// default sync byte and byte-count helpers.
package puf_soc_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t SYNC = 2'd1;
   localparam state_t DATA = 2'd2;
   localparam state_t CSUM = 2'd3;

   localparam int         DEFAULT_FRAM_SIZE = 160;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Number of payload bytes carried by one frame.
   function automatic int num_bytes(input int fram_size);
      return fram_size / 8;
   endfunction

   // Width of the payload byte index; never narrower than one bit.
   function automatic int idx_width(input int n);
      if (n <= 1)
         return 1;
      return $clog2(n);
   endfunction

endpackage

// File: rtl/puf_soc_frame_serializer.sv
// Frame serializer: buffers up to two frames (active + pending) and emits
// each as SYNC, payload bytes LSB-first, XOR checksum over a valid/ready link.
module puf_soc_frame_serializer
   import puf_soc_pkg::*;
#(
   parameter int         FRAM_SIZE  = DEFAULT_FRAM_SIZE,
   parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE,
   parameter int         DROP_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FRAM_SIZE-1:0]  i_frame_data,
   input  logic                  i_frame_valid,
   output logic [7:0]            o_tx_data,
   output logic                  o_tx_valid,
   input  logic                  i_tx_ready,
   output logic                  o_busy,
   output logic                  o_frame_done,
   output logic [DROP_CNT_W-1:0] o_drop_cnt
);

   localparam int                NUM_BYTES = num_bytes(FRAM_SIZE);
   localparam int                IDX_W     = idx_width(NUM_BYTES);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);

   state_t                  state_reg, state_next;
   logic [FRAM_SIZE-1:0]    active_reg, active_next;
   logic [FRAM_SIZE-1:0]    pending_reg, pending_next;
   logic                    pending_full_reg, pending_full_next;
   logic [7:0]              csum_reg, csum_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic [7:0]              tx_data_reg, tx_data_next;
   logic                    tx_valid_reg, tx_valid_next;
   logic                    busy_reg, busy_next;
   logic                    frame_done_reg, frame_done_next;
   logic [DROP_CNT_W-1:0]   drop_cnt_reg, drop_cnt_next;

   logic                    xfer;
   logic                    csum_take;
   logic [FRAM_SIZE-1:0]    active_shift;

   // A byte moves only when both sides agree.
   assign xfer         = tx_valid_reg & i_tx_ready;
   assign csum_take    = (state_reg == CSUM) & xfer;
   assign active_shift = active_reg >> 8;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic: sequencing only advances on a completed transfer.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (i_frame_valid) state_next = SYNC;
         SYNC: if (xfer) state_next = DATA;
         DATA: if (xfer && (idx_reg == LAST_IDX)) state_next = CSUM;
         CSUM: if (xfer) state_next = (pending_full_reg || i_frame_valid) ? SYNC : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output/datapath next values: byte presentation, checksum, buffering, drops.
   always_comb begin
      active_next       = active_reg;
      pending_next      = pending_reg;
      pending_full_next = pending_full_reg;
      csum_next         = csum_reg;
      idx_next          = idx_reg;
      tx_data_next      = tx_data_reg;
      tx_valid_next     = tx_valid_reg;
      frame_done_next   = 1'b0;
      drop_cnt_next     = drop_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (i_frame_valid) begin
               active_next   = i_frame_data;
               csum_next     = 8'h00;
               idx_next      = '0;
               tx_valid_next = 1'b1;
               tx_data_next  = SYNC_BYTE;
            end
         end
         SYNC: begin
            if (xfer)
               tx_data_next = active_reg[7:0];
         end
         DATA: begin
            if (xfer) begin
               csum_next = csum_reg ^ tx_data_reg;
               if (idx_reg == LAST_IDX) begin
                  // Checksum byte covers the payload only, never the sync byte.
                  tx_data_next = csum_reg ^ tx_data_reg;
               end else begin
                  idx_next     = idx_reg + IDX_W'(1);
                  active_next  = active_shift;
                  tx_data_next = active_shift[7:0];
               end
            end
         end
         CSUM: begin
            if (xfer) begin
               frame_done_next = 1'b1;
               csum_next       = 8'h00;
               idx_next        = '0;
               if (pending_full_reg) begin
                  active_next  = pending_reg;
                  tx_data_next = SYNC_BYTE;
               end else if (i_frame_valid) begin
                  // Pending is empty, so a coincident strobe goes straight to active.
                  active_next  = i_frame_data;
                  tx_data_next = SYNC_BYTE;
               end else begin
                  tx_valid_next = 1'b0;
               end
            end
         end
         default: ;
      endcase

      // Pending slot: it drains first on a CSUM transfer, so a coincident
      // strobe refills it rather than being dropped.
      if (csum_take && pending_full_reg) begin
         pending_full_next = i_frame_valid;
         if (i_frame_valid)
            pending_next = i_frame_data;
      end else if (i_frame_valid && (state_reg != IDLE) && !csum_take) begin
         if (!pending_full_reg) begin
            pending_next      = i_frame_data;
            pending_full_next = 1'b1;
         end else if (drop_cnt_reg != {DROP_CNT_W{1'b1}}) begin
            drop_cnt_next = drop_cnt_reg + DROP_CNT_W'(1);
         end
      end
   end

   // Busy reflects the registered state and pending slot of the next cycle.
   always_comb begin
      busy_next = (state_next != IDLE) | pending_full_next;
   end

   // Datapath and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_reg       <= '0;
         pending_reg      <= '0;
         pending_full_reg <= 1'b0;
         csum_reg         <= 8'h00;
         idx_reg          <= '0;
         tx_data_reg      <= 8'h00;
         tx_valid_reg     <= 1'b0;
         busy_reg         <= 1'b0;
         frame_done_reg   <= 1'b0;
         drop_cnt_reg     <= '0;
      end else begin
         active_reg       <= active_next;
         pending_reg      <= pending_next;
         pending_full_reg <= pending_full_next;
         csum_reg         <= csum_next;
         idx_reg          <= idx_next;
         tx_data_reg      <= tx_data_next;
         tx_valid_reg     <= tx_valid_next;
         busy_reg         <= busy_next;
         frame_done_reg   <= frame_done_next;
         drop_cnt_reg     <= drop_cnt_next;
      end
   end

   assign o_tx_data    = tx_data_reg;
   assign o_tx_valid   = tx_valid_reg;
   assign o_busy       = busy_reg;
   assign o_frame_done = frame_done_reg;
   assign o_drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_puf_soc_frame_serializer.sv
// Randomized and directed bench for the frame serializer, scored against a
// queue-based model of the frame stream.
module tb_puf_soc_frame_serializer;

   localparam int FS = 160;
   localparam int NB = FS / 8;
   localparam int STREAM_LEN = NB + 2;

   logic          clk;
   logic          rst_n;
   logic [FS-1:0] i_frame_data;
   logic          i_frame_valid;
   logic [7:0]    o_tx_data;
   logic          o_tx_valid;
   logic          i_tx_ready;
   logic          o_busy;
   logic          o_frame_done;
   logic [7:0]    o_drop_cnt;

   puf_soc_frame_serializer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_frame_data  (i_frame_data),
      .i_frame_valid (i_frame_valid),
      .o_tx_data     (o_tx_data),
      .o_tx_valid    (o_tx_valid),
      .i_tx_ready    (i_tx_ready),
      .o_busy        (o_busy),
      .o_frame_done  (o_frame_done),
      .o_drop_cnt    (o_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int chk_cnt = 0;
   int err_cnt = 0;

   // Model: frames accepted but not yet fully sent, position within head frame.
   logic [FS-1:0] mq[$];
   int            pos = 0;
   int            drops = 0;
   logic          exp_done = 1'b0;
   int            frames_sent = 0;
   int            done_seen = 0;
   int            cyc = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Byte p of a frame's stream: sync, payload LSB-first, XOR of payload.
   function automatic logic [7:0] stream_byte(input logic [FS-1:0] f, input int p);
      logic [7:0] x;
      if (p == 0)
         return 8'hA5;
      if (p <= NB)
         return f[8*(p-1) +: 8];
      x = 8'h00;
      for (int k = 0; k < NB; k++)
         x = x ^ f[8*k +: 8];
      return x;
   endfunction

   function automatic logic [FS-1:0] rand_frame();
      logic [FS-1:0] f;
      for (int k = 0; k < FS / 32; k++)
         f[32*k +: 32] = $urandom;
      return f;
   endfunction

   task automatic compare_outputs();
      logic exp_valid;
      exp_valid = (mq.size() > 0);
      check_eq("tx_valid", o_tx_valid, exp_valid);
      if (exp_valid)
         check_eq("tx_data", o_tx_data, stream_byte(mq[0], pos));
      check_eq("frame_done", o_frame_done, exp_done);
      check_eq("busy", o_busy, exp_valid);
      check_eq("drop_cnt", o_drop_cnt, drops);
      if (o_frame_done)
         done_seen++;
   endtask

   // One clock: apply inputs, advance the model for the coming edge, check.
   task automatic cycle(input logic fv, input logic [FS-1:0] d, input logic rdy);
      i_frame_valid = fv;
      i_frame_data  = d;
      i_tx_ready    = rdy;
      exp_done = 1'b0;
      if (mq.size() > 0 && rdy) begin
         pos++;
         if (pos == STREAM_LEN) begin
            void'(mq.pop_front());
            pos = 0;
            exp_done = 1'b1;
            frames_sent++;
            $display("frame %0d complete at cycle %0d, queued %0d, drops %0d",
                     frames_sent, cyc, mq.size(), drops);
         end
      end
      if (fv) begin
         if (mq.size() < 2)
            mq.push_back(d);
         else if (drops < 255)
            drops++;
      end
      @(negedge clk);
      cyc++;
      compare_outputs();
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && mq.size() > 0; i++)
         cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      check_eq("drained_busy", o_busy, 1'b0);
   endtask

   task automatic model_reset();
      mq.delete();
      pos = 0;
      drops = 0;
      exp_done = 1'b0;
   endtask

   initial begin
      logic [FS-1:0] f;
      int            done_before;

      rst_n = 1'b0;
      i_frame_valid = 1'b0;
      i_frame_data = '0;
      i_tx_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_tx_data", o_tx_data, 8'h00);
      check_eq("rst_tx_valid", o_tx_valid, 1'b0);
      check_eq("rst_busy", o_busy, 1'b0);
      check_eq("rst_frame_done", o_frame_done, 1'b0);
      check_eq("rst_drop_cnt", o_drop_cnt, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: all-zero frame, ready held high.
      cycle(1'b1, '0, 1'b1);
      drain();

      // 2: payload bytes 01..14, checksum 0x14.
      for (int k = 0; k < NB; k++)
         f[8*k +: 8] = 8'(k + 1);
      check_eq("csum_0x14", stream_byte(f, NB + 1), 8'h14);
      cycle(1'b1, f, 1'b1);
      drain();

      // 3: same frame, ready toggling with a 5-cycle stall mid-DATA.
      cycle(1'b1, f, 1'b0);
      for (int i = 0; i < 200 && mq.size() > 0; i++)
         cycle(1'b0, '0, (i >= 12 && i < 17) ? 1'b0 : 1'(i % 2));
      drain();

      // 4: three strobes with ready low: two buffered, one dropped.
      cycle(1'b1, rand_frame(), 1'b0);
      cycle(1'b0, '0, 1'b0);
      cycle(1'b1, rand_frame(), 1'b0);
      cycle(1'b0, '0, 1'b0);
      cycle(1'b1, rand_frame(), 1'b0);
      cycle(1'b0, '0, 1'b0);
      check_eq("drop_after_three", o_drop_cnt, 8'd1);
      drain();

      // 5: strobe coincident with CSUM transfer while pending is full.
      done_before = done_seen;
      cycle(1'b1, rand_frame(), 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b1, rand_frame(), 1'b1);
      for (int i = 0; i < 100 && !(mq.size() == 2 && pos == STREAM_LEN - 1); i++)
         cycle(1'b0, '0, 1'b1);
      cycle(1'b1, rand_frame(), 1'b1);
      drain();
      check_eq("coincident_frames", done_seen - done_before, 3);
      check_eq("coincident_drop", o_drop_cnt, 8'd1);

      // 6: reset at DATA byte 7, then fresh frame.
      cycle(1'b1, rand_frame(), 1'b1);
      for (int i = 0; i < 50 && pos != 8; i++)
         cycle(1'b0, '0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_tx_data", o_tx_data, 8'h00);
      check_eq("arst_tx_valid", o_tx_valid, 1'b0);
      check_eq("arst_busy", o_busy, 1'b0);
      check_eq("arst_frame_done", o_frame_done, 1'b0);
      check_eq("arst_drop_cnt", o_drop_cnt, 8'h00);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, rand_frame(), 1'b1);
      check_eq("fresh_sync", o_tx_data, 8'hA5);
      drain();

      // Saturation: 300 strobes with ready low.
      for (int i = 0; i < 300; i++)
         cycle(1'b1, rand_frame(), 1'b0);
      check_eq("drop_saturated", o_drop_cnt, 8'hFF);
      drain();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++)
         cycle(($urandom_range(0, 15) == 0), rand_frame(), ($urandom_range(0, 3) != 0));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule
